reg_dump_reader: RTL and testbench

- Debug-side reader for the 32-entry CPU register file; drives the file's third read address port (asynchronous read) and streams register contents out over a valid/ready handshake.
- Supports a full scan of all 32 registers or a single read of one selected register.
- Sits between register_file and the debug/display unit.
- Asserts freeze while busy so the CPU can stall writeback and produce a consistent snapshot.

---
 rtl/cpu_dbg_pkg.sv | 16 +
 rtl/reg_dump_reader.sv | 129 ++++++++++++
 tb/tb_reg_dump_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared constants and state encoding for the CPU debug register-dump path.
package cpu_dbg_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;

  localparam logic [REG_AW-1:0] LAST_REG = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug-side register file reader: scans all registers (or reads one) through
// the file's asynchronous debug read port and streams {addr, data} words out
// over valid/ready. freeze asks the CPU to hold writeback while busy.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// READ   | rf_ra settled, capture rf_rd into the output word
// SEND   | word presented, wait for consumer acceptance
// FIN    | one-cycle done pulse, then back to IDLE
module reg_dump_reader
  import cpu_dbg_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              single,
  input  logic [REG_AW-1:0] sel,
  input  logic              abort,
  output logic [REG_AW-1:0] rf_ra,
  input  logic [WIDTH-1:0]  rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_addr,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  output logic              freeze,
  output logic              done
);

  state_t            state;
  logic [REG_AW-1:0] addr;
  logic              mode;
  logic [REG_AW-1:0] first_addr;
  logic              last_word;

  // Starting index: the selected register for a single read, otherwise the
  // bottom of the file (r0 is skipped in scans when it is known to be zero).
  always_comb begin
    first_addr = 5'd0;
    if (single)         first_addr = sel;
    else if (SKIP_ZERO) first_addr = 5'd1;
  end

  // A scan stops at the top register so the counter never wraps.
  always_comb begin
    last_word = mode || (addr == LAST_REG);
  end

  // freeze is the same registered flag as busy.
  assign freeze = busy;

  // Main sequencer: state, address counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      mode      <= 1'b0;
      rf_ra     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode  <= single;
            addr  <= first_addr;
            rf_ra <= first_addr;
            busy  <= 1'b1;
            state <= S_READ;
          end
        end

        S_READ: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            out_data  <= rf_rd;
            out_addr  <= addr;
            out_valid <= 1'b1;
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          // abort wins over a same-cycle acceptance
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (last_word) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              addr  <= addr + 5'd1;
              rf_ra <= addr + 5'd1;
              state <= S_READ;
            end
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: stimulus pushes expected words, a
// negedge monitor pops and compares on each accepted word.
module tb_reg_dump_reader;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  // instance with SKIP_ZERO=0
  logic        start = 1'b0, single = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [4:0]  sel = 5'd0;
  logic [4:0]  rf_ra, out_addr;
  logic [31:0] rf_rd, out_data;
  logic        out_valid, busy, freeze, done;

  // instance with SKIP_ZERO=1
  logic        start_sz = 1'b0, ready_sz = 1'b0;
  logic [4:0]  rf_ra_sz, out_addr_sz;
  logic [31:0] rf_rd_sz, out_data_sz;
  logic        out_valid_sz, busy_sz, freeze_sz, done_sz;

  logic [31:0] rf [32];
  assign rf_rd    = rf[rf_ra];
  assign rf_rd_sz = rf[rf_ra_sz];

  reg_dump_reader #(.WIDTH(32), .SKIP_ZERO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .single(single), .sel(sel),
    .abort(abort), .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .freeze(freeze), .done(done)
  );

  reg_dump_reader #(.WIDTH(32), .SKIP_ZERO(1'b1)) dut_sz (
    .clk(clk), .rst_n(rst_n), .start(start_sz), .single(1'b0), .sel(5'd0),
    .abort(1'b0), .rf_ra(rf_ra_sz), .rf_rd(rf_rd_sz), .out_valid(out_valid_sz),
    .out_ready(ready_sz), .out_addr(out_addr_sz), .out_data(out_data_sz),
    .busy(busy_sz), .freeze(freeze_sz), .done(done_sz)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  word_t exp_q[$];
  word_t exp_q_sz[$];
  int done_cnt = 0, done_cyc = 0, acc_cnt = 0, acc_cyc = 0;
  int done_cnt_sz = 0, acc_cnt_sz = 0;
  logic        hold_v = 1'b0;
  logic [4:0]  hold_a;
  logic [31:0] hold_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the SKIP_ZERO=0 instance: word compare and hold stability.
  always @(negedge clk) begin
    word_t e;
    if (rst_n && out_valid && hold_v) begin
      chk("hold_addr", 64'(out_addr), 64'(hold_a));
      chk("hold_data", 64'(out_data), 64'(hold_d));
    end
    hold_v = 1'b0;
    if (rst_n && out_valid) begin
      if (out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: got addr %0d data 0x%0h, expected none", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_addr", 64'(out_addr), 64'(e.a));
          chk("word_data", 64'(out_data), 64'(e.d));
        end
        acc_cnt++;
        acc_cyc = cyc;
      end else if (!out_ready) begin
        hold_v = 1'b1; hold_a = out_addr; hold_d = out_data;
      end
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Monitor for the SKIP_ZERO=1 instance.
  always @(negedge clk) begin
    word_t e;
    if (rst_n && out_valid_sz && ready_sz) begin
      if (exp_q_sz.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_word_sz: got addr %0d, expected none", out_addr_sz);
      end else begin
        e = exp_q_sz.pop_front();
        chk("sz_word_addr", 64'(out_addr_sz), 64'(e.a));
        chk("sz_word_data", 64'(out_data_sz), 64'(e.d));
      end
      acc_cnt_sz++;
    end
    if (rst_n && done_sz) done_cnt_sz++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back({5'(i), 32'(i) * 32'h0101});
  endtask

  // Wait for a done pulse on the selected instance within max cycles.
  task automatic wait_done(input bit sz, input int max, input bit toggle, input string name);
    int d0;
    int n;
    d0 = sz ? done_cnt_sz : done_cnt;
    n = 0;
    while (((sz ? done_cnt_sz : done_cnt) == d0) && n < max) begin
      if (toggle) out_ready = (n % 4 == 0);
      tick;
      n++;
    end
    chk({name, "_done_seen"}, 64'((sz ? done_cnt_sz : done_cnt) - d0), 64'd1);
  endtask

  initial begin
    int s_cyc;
    int d0;
    int n;
    bit found;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101;

    // reset state
    #3 rst_n = 1'b0;
    #5;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr",  64'(out_addr),  64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_rf_ra",     64'(rf_ra),     64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_freeze",    64'(freeze),    64'd0);
    chk("rst_done",      64'(done),      64'd0);
    #14 rst_n = 1'b1;
    tick;

    // full scan, ready always high
    out_ready = 1'b1;
    push_scan(0, 31);
    start = 1'b1;
    tick;
    s_cyc = cyc;
    start = 1'b0;
    chk("scan_busy", 64'(busy), 64'd1);
    chk("scan_freeze", 64'(freeze), 64'd1);
    wait_done(1'b0, 200, 1'b0, "scan");
    chk("scan_done_cycle", 64'(done_cyc - s_cyc), 64'd64);
    chk("scan_words_left", 64'(exp_q.size()), 64'd0);
    tick;
    chk("scan_done_width", 64'(done), 64'd0);
    chk("scan_busy_after", 64'(busy), 64'd0);

    // full scan with ready 1 high / 3 low
    push_scan(0, 31);
    out_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(1'b0, 400, 1'b1, "toggle");
    chk("toggle_words_left", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;
    tick;

    // single read of r7
    rf[7] = 32'hDEADBEEF;
    exp_q.push_back({5'd7, 32'hDEADBEEF});
    d0 = acc_cnt;
    start = 1'b1; single = 1'b1; sel = 5'd7;
    tick;
    start = 1'b0; single = 1'b0; sel = 5'd0;
    wait_done(1'b0, 20, 1'b0, "single");
    chk("single_word_count", 64'(acc_cnt - d0), 64'd1);
    chk("single_done_after_accept", 64'(done_cyc - acc_cyc), 64'd1);
    rf[7] = 32'h0707;
    tick;
    tick;
    chk("single_no_extra", 64'(acc_cnt - d0), 64'd1);

    // SKIP_ZERO scan: r1..r31
    ready_sz = 1'b1;
    for (int i = 1; i <= 31; i++) exp_q_sz.push_back({5'(i), 32'(i) * 32'h0101});
    d0 = acc_cnt_sz;
    start_sz = 1'b1;
    tick;
    start_sz = 1'b0;
    wait_done(1'b1, 200, 1'b0, "sz");
    chk("sz_word_count", 64'(acc_cnt_sz - d0), 64'd31);
    chk("sz_words_left", 64'(exp_q_sz.size()), 64'd0);

    // abort while presenting r12 with ready high
    push_scan(0, 11);
    d0 = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      if (out_valid && out_addr == 5'd12) found = 1'b1;
      else begin tick; n++; end
    end
    chk("abort_reached_r12", 64'(found), 64'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy",  64'(busy), 64'd0);
    chk("abort_freeze", 64'(freeze), 64'd0);
    tick; tick; tick;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_words_left", 64'(exp_q.size()), 64'd0);
    push_scan(0, 31);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(1'b0, 200, 1'b0, "restart");
    chk("restart_words_left", 64'(exp_q.size()), 64'd0);
    tick;

    // start ignored in SEND, then async reset mid-scan
    out_ready = 1'b0;
    push_scan(0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("hold_first_valid", 64'(out_valid), 64'd1);
    start = 1'b1;
    tick; tick;
    start = 1'b0;
    chk("start_ign_addr",  64'(out_addr), 64'd0);
    chk("start_ign_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    tick;
    chk("after_ign_addr", 64'(out_addr), 64'd1);
    chk("after_ign_data", 64'(out_data), 64'h0101);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_addr",  64'(out_addr),  64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_rf_ra",     64'(rf_ra),     64'd0);
    chk("arst_busy",      64'(busy),      64'd0);
    chk("arst_freeze",    64'(freeze),    64'd0);
    #2 rst_n = 1'b1;
    tick; tick;
    chk("arst_stays_idle", 64'(busy), 64'd0);
    chk("final_words_left", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
